// File: rtl/game_pkg.sv
// Shared types and constants for the card-game scoring stage.
//   CARD_W/NUM_W/COLOR_W : card bus layout, [4:3] colour, [2:0] number
//   SCORE_W              : width of raw and bonus-adjusted scores
//   state_t              : judge FSM states
//   WIN_*                : encoding of the winner output
package game_pkg;

  localparam int CARD_W  = 5;
  localparam int NUM_W   = 3;
  localparam int COLOR_W = 2;
  localparam int SCORE_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    JUDGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  function automatic logic [NUM_W-1:0] card_num(input logic [CARD_W-1:0] card);
    return card[NUM_W-1:0];
  endfunction

  function automatic logic [COLOR_W-1:0] card_color(input logic [CARD_W-1:0] card);
    return card[CARD_W-1:NUM_W];
  endfunction

endpackage

// File: rtl/hand_acc.sv
// One player's hand: accumulates score and card count, tracks bust,
// stand and whether every card so far shares one colour.
//   clk, rst     : clock, asynchronous active-low reset
//   clr          : synchronous clear at the start of a game
//   accept       : take `card` this cycle (caller has already checked eligible)
//   stand        : player stands (ignored once bust)
//   card         : {colour, number}
//   score, count : raw sum of numbers and number of cards held
//   bust         : raw score above SUM_LIMIT
//   eligible     : may still receive a card
//   finished     : stood, bust or hand full
//   final_score  : score plus flush bonus, used only for judging
module hand_acc
  import game_pkg::*;
#(
  parameter int HAND_MAX    = 5,
  parameter int SUM_LIMIT   = 21,
  parameter int FLUSH_BONUS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               accept,
  input  logic               stand,
  input  logic [CARD_W-1:0]  card,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         count,
  output logic               bust,
  output logic               eligible,
  output logic               finished,
  output logic [SCORE_W-1:0] final_score
);

  localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(SUM_LIMIT);
  localparam logic [SCORE_W-1:0] BONUS = SCORE_W'(FLUSH_BONUS);
  localparam logic [2:0]         MAXC  = 3'(HAND_MAX);

  logic               stood;
  logic               same_col;
  logic [COLOR_W-1:0] colour_ref;
  logic [SCORE_W-1:0] score_nx;

  assign score_nx = score + SCORE_W'(card_num(card));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score      <= '0;
      count      <= '0;
      bust       <= 1'b0;
      stood      <= 1'b0;
      same_col   <= 1'b0;
      colour_ref <= '0;
    end else if (clr) begin
      score      <= '0;
      count      <= '0;
      bust       <= 1'b0;
      stood      <= 1'b0;
      same_col   <= 1'b0;
      colour_ref <= '0;
    end else begin
      if (accept) begin
        score <= score_nx;
        count <= count + 3'd1;
        bust  <= (score_nx > LIMIT);
        // The first card defines the reference colour; any later
        // mismatch permanently breaks the flush.
        if (count == 3'd0) begin
          colour_ref <= card_color(card);
          same_col   <= 1'b1;
        end else if (card_color(card) != colour_ref) begin
          same_col   <= 1'b0;
        end
      end
      if (stand && !bust) begin
        stood <= 1'b1;
      end
    end
  end

  assign eligible    = !stood && !bust && (count < MAXC);
  assign finished    = stood || bust || (count == MAXC);
  assign final_score = score + ((same_col && (count >= 3'd2)) ? BONUS : '0);

endmodule

// File: rtl/hand_judge.sv
// Scoring stage of the card game: routes cards and stand requests to the
// two hands, waits until both are finished, then declares the winner.
//   clk, rst                 : clock, asynchronous active-low reset
//   start                    : clear and begin a new game (top priority)
//   card_valid, stand, whose : card / stand pulses for player `whose`
//   card_value1, card_value2 : per-player card buses {colour, number}
//   score1/2, count1/2       : raw score and cards held
//   bust1/2                  : raw score above SUM_LIMIT
//   winner                   : 00 pending, 01 p1, 10 p2, 11 tie
//   done                     : winner valid, held until the next start
module hand_judge
  import game_pkg::*;
#(
  parameter int HAND_MAX    = 5,
  parameter int SUM_LIMIT   = 21,
  parameter int FLUSH_BONUS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               card_valid,
  input  logic               stand,
  input  logic               whose,
  input  logic [CARD_W-1:0]  card_value1,
  input  logic [CARD_W-1:0]  card_value2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [2:0]         count1,
  output logic [2:0]         count2,
  output logic               bust1,
  output logic               bust2,
  output logic [1:0]         winner,
  output logic               done
);

  state_t             state, state_nx;
  logic               in_play;
  logic               acc1, acc2, st1, st2;
  logic               elig1, elig2, fin1, fin2;
  logic [SCORE_W-1:0] final1, final2;
  logic [1:0]         verdict;

  assign in_play = (state == PLAY) && !start;
  assign acc1    = in_play && card_valid && !whose && elig1;
  assign acc2    = in_play && card_valid &&  whose && elig2;
  assign st1     = in_play && stand && !whose;
  assign st2     = in_play && stand &&  whose;

  hand_acc #(
    .HAND_MAX(HAND_MAX), .SUM_LIMIT(SUM_LIMIT), .FLUSH_BONUS(FLUSH_BONUS)
  ) u_p1 (
    .clk(clk), .rst(rst), .clr(start), .accept(acc1), .stand(st1),
    .card(card_value1), .score(score1), .count(count1), .bust(bust1),
    .eligible(elig1), .finished(fin1), .final_score(final1)
  );

  hand_acc #(
    .HAND_MAX(HAND_MAX), .SUM_LIMIT(SUM_LIMIT), .FLUSH_BONUS(FLUSH_BONUS)
  ) u_p2 (
    .clk(clk), .rst(rst), .clr(start), .accept(acc2), .stand(st2),
    .card(card_value2), .score(score2), .count(count2), .bust(bust2),
    .eligible(elig2), .finished(fin2), .final_score(final2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = PLAY;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        PLAY:    if (fin1 && fin2) state_nx = JUDGE;
        JUDGE:   state_nx = DONE;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Bust overrides the bonus-adjusted comparison entirely.
  always_comb begin
    verdict = WIN_TIE;
    if (bust1 && bust2)     verdict = WIN_TIE;
    else if (bust1)         verdict = WIN_P2;
    else if (bust2)         verdict = WIN_P1;
    else if (final1 > final2) verdict = WIN_P1;
    else if (final2 > final1) verdict = WIN_P2;
    else                    verdict = WIN_TIE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner <= WIN_NONE;
      done   <= 1'b0;
    end else if (start) begin
      winner <= WIN_NONE;
      done   <= 1'b0;
    end else if (state == JUDGE) begin
      winner <= verdict;
      done   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hand_judge.sv
module tb_hand_judge;
  localparam int HM = 5, SL = 21, FB = 5;

  logic       clk = 1'b0;
  logic       rst, start, card_valid, stand, whose;
  logic [4:0] card_value1, card_value2;
  logic [5:0] score1, score2;
  logic [2:0] count1, count2;
  logic       bust1, bust2, done;
  logic [1:0] winner;

  hand_judge #(.HAND_MAX(HM), .SUM_LIMIT(SL), .FLUSH_BONUS(FB)) dut (
    .clk(clk), .rst(rst), .start(start), .card_valid(card_valid),
    .stand(stand), .whose(whose), .card_value1(card_value1),
    .card_value2(card_value2), .score1(score1), .score2(score2),
    .count1(count1), .count2(count2), .bust1(bust1), .bust2(bust2),
    .winner(winner), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic st, cv, sd, wh;
    logic [4:0] c;
    int s1, s2, n1, n2, b1, b2, w, d;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [4:0] cd(input int col, input int num);
    return 5'(col * 8 + num);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string t, input int s1, s2, n1, n2, b1, b2, w, d);
    chk({t, " score1"}, 8'(score1), 8'(s1));
    chk({t, " score2"}, 8'(score2), 8'(s2));
    chk({t, " count1"}, 8'(count1), 8'(n1));
    chk({t, " count2"}, 8'(count2), 8'(n2));
    chk({t, " bust1"},  8'(bust1),  8'(b1));
    chk({t, " bust2"},  8'(bust2),  8'(b2));
    chk({t, " winner"}, 8'(winner), 8'(w));
    chk({t, " done"},   8'(done),   8'(d));
  endtask

  task automatic cyc(input logic st, cv, sd, wh, input logic [4:0] c1, c2);
    start = st; card_valid = cv; stand = sd; whose = wh;
    card_value1 = c1; card_value2 = c2;
    @(posedge clk); #1;
    start = 0; card_valid = 0; stand = 0;
  endtask

  // Card goes on the selected player's bus; the other bus carries junk.
  task automatic add(input logic st, cv, sd, wh, input logic [4:0] c,
                     input int s1, s2, n1, n2, b1, b2, w, d);
    vec_t v;
    v = '{st, cv, sd, wh, c, s1, s2, n1, n2, b1, b2, w, d};
    tbl.push_back(v);
  endtask

  // Reference model: hands kept as lists of cards, game as a phase.
  int mnum[2][HM], mcol[2][HM], mcnt[2];
  bit mstood[2];
  int mphase;   // 0 idle, 1 playing, 2 judging, 3 result shown
  int mwin;
  int mdone;

  function automatic int msum(input int p);
    int s = 0;
    for (int i = 0; i < mcnt[p]; i++) s += mnum[p][i];
    return s;
  endfunction

  function automatic int mbust(input int p);
    return (msum(p) > SL) ? 1 : 0;
  endfunction

  function automatic bit mfin(input int p);
    return mstood[p] || (mbust(p) == 1) || (mcnt[p] == HM);
  endfunction

  function automatic int mfinal(input int p);
    bit flush = (mcnt[p] >= 2);
    for (int i = 1; i < mcnt[p]; i++) if (mcol[p][i] != mcol[p][0]) flush = 0;
    return msum(p) + (flush ? FB : 0);
  endfunction

  task automatic mstep(input logic st, cv, sd, wh, input logic [4:0] c1, c2);
    int p;
    bit both;
    logic [4:0] c;
    if (st) begin
      mcnt = '{0, 0}; mstood = '{0, 0}; mphase = 1; mwin = 0; mdone = 0;
    end else if (mphase == 1) begin
      both = mfin(0) && mfin(1);
      p = wh ? 1 : 0;
      c = wh ? c2 : c1;
      if (cv && !mstood[p] && mbust(p) == 0 && mcnt[p] < HM) begin
        mnum[p][mcnt[p]] = int'(c[2:0]);
        mcol[p][mcnt[p]] = int'(c[4:3]);
        mcnt[p]++;
      end
      if (sd && mbust(p) == 0) mstood[p] = 1;
      if (both) mphase = 2;
    end else if (mphase == 2) begin
      if (mbust(0) == 1 && mbust(1) == 1) mwin = 3;
      else if (mbust(0) == 1)             mwin = 2;
      else if (mbust(1) == 1)             mwin = 1;
      else if (mfinal(0) > mfinal(1))     mwin = 1;
      else if (mfinal(1) > mfinal(0))     mwin = 2;
      else                                mwin = 3;
      mdone = 1;
      mphase = 3;
    end
  endtask

  initial begin
    rst = 0; start = 0; card_valid = 0; stand = 0; whose = 0;
    card_value1 = 0; card_value2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1;

    // Basic player-1 win
    add(1,0,0,0,0,          0, 0,0,0,0,0,0,0);
    add(0,1,0,0,cd(0,7),    7, 0,1,0,0,0,0,0);
    add(0,1,0,0,cd(1,6),   13, 0,2,0,0,0,0,0);
    add(0,0,1,0,0,         13, 0,2,0,0,0,0,0);
    add(0,1,0,1,cd(0,5),   13, 5,2,1,0,0,0,0);
    add(0,1,0,1,cd(2,4),   13, 9,2,2,0,0,0,0);
    add(0,0,1,1,0,         13, 9,2,2,0,0,0,0);
    add(0,0,0,0,0,         13, 9,2,2,0,0,0,0);
    add(0,0,0,0,0,         13, 9,2,2,0,0,1,1);
    add(0,1,0,0,cd(0,1),   13, 9,2,2,0,0,1,1);
    // Bust at 22, 21 is not bust, further card ignored
    add(1,0,0,0,0,          0, 0,0,0,0,0,0,0);
    add(0,1,0,0,cd(0,7),    7, 0,1,0,0,0,0,0);
    add(0,1,0,0,cd(0,7),   14, 0,2,0,0,0,0,0);
    add(0,1,0,0,cd(0,7),   21, 0,3,0,0,0,0,0);
    add(0,1,0,0,cd(0,1),   22, 0,4,0,1,0,0,0);
    add(0,1,0,0,cd(0,3),   22, 0,4,0,1,0,0,0);
    add(0,1,0,1,cd(1,3),   22, 3,4,1,1,0,0,0);
    add(0,0,1,1,0,         22, 3,4,1,1,0,0,0);
    add(0,0,0,0,0,         22, 3,4,1,1,0,0,0);
    add(0,0,0,0,0,         22, 3,4,1,1,0,2,1);
    // Flush bonus: 10+5 vs 15 tie, then 10+5 vs 16
    for (int v = 0; v < 2; v++) begin
      add(1,0,0,0,0,          0, 0,0,0,0,0,0,0);
      add(0,1,0,0,cd(2,5),    5, 0,1,0,0,0,0,0);
      add(0,1,0,0,cd(2,5),   10, 0,2,0,0,0,0,0);
      add(0,0,1,0,0,         10, 0,2,0,0,0,0,0);
      add(0,1,0,1,cd(1,7),   10, 7,2,1,0,0,0,0);
      add(0,1,0,1,cd(3,7),   10,14,2,2,0,0,0,0);
      add(0,1,0,1,cd(0,1+v), 10,15+v,2,3,0,0,0,0);
      add(0,0,1,1,0,         10,15+v,2,3,0,0,0,0);
      add(0,0,0,0,0,         10,15+v,2,3,0,0,0,0);
      add(0,0,0,0,0,         10,15+v,2,3,0,0,(v == 0) ? 3 : 2,1);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].st, tbl[i].cv, tbl[i].sd, tbl[i].wh,
          tbl[i].wh ? 5'h1F : tbl[i].c, tbl[i].wh ? tbl[i].c : 5'h1F);
      check_outs($sformatf("vec%0d", i), tbl[i].s1, tbl[i].s2, tbl[i].n1,
                 tbl[i].n2, tbl[i].b1, tbl[i].b2, tbl[i].w, tbl[i].d);
    end

    // Full hand of five, then simultaneous card+stand for player 2
    cyc(1,0,0,0,0,0);
    for (int i = 0; i < 5; i++) cyc(0,1,0,0,cd(0,1),5'h1F);
    check_outs("full_hand", 5,0,5,0,0,0,0,0);
    cyc(0,1,0,0,cd(0,1),5'h1F);
    check_outs("sixth_card", 5,0,5,0,0,0,0,0);
    cyc(0,1,1,1,5'h1F,cd(0,3));
    check_outs("card_and_stand", 5,3,5,1,0,0,0,0);
    cyc(0,0,0,0,0,0);
    check_outs("hm_judge", 5,3,5,1,0,0,0,0);
    cyc(0,0,0,0,0,0);
    check_outs("hm_done", 5,3,5,1,0,0,1,1);

    // Restart mid-game, start beats a same-cycle card
    cyc(1,0,0,0,0,0);
    cyc(0,1,0,0,cd(0,4),5'h1F);
    cyc(0,1,0,0,cd(1,5),5'h1F);
    check_outs("pre_abort", 9,0,2,0,0,0,0,0);
    cyc(1,1,0,0,cd(0,6),5'h1F);
    check_outs("abort", 0,0,0,0,0,0,0,0);
    cyc(0,1,0,0,cd(0,2),5'h1F);
    check_outs("after_abort", 2,0,1,0,0,0,0,0);
    cyc(0,0,1,0,0,0);
    cyc(0,0,1,1,0,0);
    cyc(0,0,0,0,0,0);
    check_outs("in_judge", 2,0,1,0,0,0,0,0);
    rst = 0;
    #1;
    check_outs("async_rst", 0,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    rst = 1;
    cyc(0,1,0,0,cd(0,3),5'h1F);
    check_outs("idle_card", 0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0);
    cyc(0,0,0,0,0,0);
    check_outs("idle_stays", 0,0,0,0,0,0,0,0);

    // Randomised games against the reference model
    mphase = 0; mcnt = '{0, 0}; mstood = '{0, 0}; mwin = 0; mdone = 0;
    for (int g = 0; g < 25; g++) begin
      for (int k = 0; k < 40; k++) begin
        logic st, cv, sd, wh;
        logic [4:0] c1, c2;
        st = (k == 0) || ($urandom_range(0, 59) == 0);
        cv = ($urandom_range(0, 9) < 6);
        sd = ($urandom_range(0, 9) == 0);
        wh = 1'($urandom);
        c1 = 5'($urandom);
        c2 = 5'($urandom);
        mstep(st, cv, sd, wh, c1, c2);
        cyc(st, cv, sd, wh, c1, c2);
        check_outs($sformatf("rnd%0d_%0d", g, k), msum(0), msum(1), mcnt[0],
                   mcnt[1], mbust(0), mbust(1), mwin, mdone);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hand_judge.md
# hand_judge

Downstream scoring stage of the card game. Consumes the per-player card values produced by the two `card_value` instances, using `number` [2:0] and `color` [4:3].
- Accumulates each player's hand, tracks bust, stand and same-colour status.
- Once both hands are finished, declares the winner.
- Results drive the display/LED stage.

## Interface
Parameters:
- HAND_MAX, 5: maximum cards per hand.
- SUM_LIMIT, 21: a raw score above this value is a bust.
- FLUSH_BONUS, 5: added to a non-bust hand of two or more cards that all share one colour.
- Constraint: HAND_MAX*7 + FLUSH_BONUS ≤ 63.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse: clear and begin a new game.
- card_valid  in  1  one-cycle pulse: new card present on the selected value bus.
- stand  in  1  one-cycle pulse: the player selected by `whose` stands.
- whose  in  1  0 = player1, 1 = player2; qualifies `card_valid` and `stand`.
- card_value1  in  5  player1 card: [4:3] colour, [2:0] number.
- card_value2  in  5  player2 card: same format.
- score1, score2  out  6  raw accumulated number sum.
- count1, count2  out  3  cards held.
- bust1, bust2  out  1  raw score > SUM_LIMIT.
- winner  out  2  00 pending, 01 player1, 10 player2, 11 tie.
- done  out  1  result valid; held until the next `start`.

## Operation
States: IDLE → PLAY → JUDGE → DONE.
- **Reset (rst=0)**: state IDLE. All scores, counts, busts, stood flags, colour flags, `winner` and `done` are 0.
- **start**: clears all per-player registers, `winner` and `done`, then enters PLAY.
  - Honoured in every state, including mid-PLAY and JUDGE.
  - Has priority over `card_valid`/`stand` in the same cycle; those are dropped.
- **Card in PLAY** (`card_valid`=1): the card is taken from `card_value1` if `whose`=0, else from `card_value2`. It is accepted only if that player is eligible (not stood, not bust, count < HAND_MAX). On acceptance:
  - score += number (0–7 at face value); count += 1.
  - First card latches colour_ref and sets same_col=1.
  - A later card whose colour ≠ colour_ref clears same_col.
  - bust is set if the new score > SUM_LIMIT.
- **Ignored inputs**: cards to an ineligible player, `card_valid` or `stand` outside PLAY, and `stand` to a bust player are all ignored with no side effects.
- **stand in PLAY**: sets the stood flag of the player selected by `whose`. If `card_valid` and `stand` arrive in the same cycle, the card is applied first (subject to eligibility), then stood is set.
- **Finished player**: stood OR bust OR count == HAND_MAX.
- **PLAY → JUDGE**: when both players are finished.
- **JUDGE** (one cycle) computes final_i = score_i + (same_col_i && count_i ≥ 2 ? FLUSH_BONUS : 0). Outcome:
  - Both bust → 11.
  - Exactly one bust → the other player wins.
  - Otherwise the higher final wins; equal finals → 11.
- **JUDGE → DONE**: `winner` registered and `done`=1. DONE holds all outputs until `start`.
- `score`/`count`/`bust` always show raw values; the bonus affects only the comparison.

## Timing
- An input sampled at edge k produces updated score, count and bust after edge k (visible in cycle k+1).
- The finished check is combinational on registered flags. If the last finishing event is at edge k, state = JUDGE after edge k+1 and `done`/`winner` are valid after edge k+2.
- `start` at edge k: IDLE/other → PLAY with cleared outputs after edge k. `done` falls at the same edge.
- rst asserted mid-game: immediate asynchronous clear. Nothing survives.
- Upstream `card_value` is registered. The system aligns `card_valid` with the bus cycle in which the value is stable; this block does not add a delay.

## Structure
- Package `game_pkg`:
  - CARD_W=5, NUM_W=3, COLOR_W=2, SCORE_W=6.
  - State enum {IDLE, PLAY, JUDGE, DONE}.
  - Winner codes WIN_NONE, WIN_P1, WIN_P2, WIN_TIE.
- Sub-module `hand_acc`, instantiated twice, one per player. It holds:
  - score, count, bust, stood, colour_ref, same_col.
  - Inputs: clr, accept-card, stand, card.
  - Outputs: eligible, finished, final.
- Top-level `hand_judge` contains the FSM, input routing and the comparator.

## Test plan
1. **Basic p1 win.** start; p1 cards (col0,n7),(col1,n6), stand; p2 cards (col0,n5),(col2,n4), stand → score1=13, score2=9, winner=01, `done` 2 cycles after p2 stand.
2. **Bust.** p1 cards n7,n7,n7,n1 → score1=22, bust1=1 after the 4th card; a further p1 card is ignored (count1 stays 4). p2 stand with score 3 → winner=10.
3. **Flush bonus and tie.**
   - p1 cards (col2,n5),(col2,n5) → final 15.
   - p2 cards (col1,n7),(col3,n7),(col0,n1) → 15, winner=11.
   - Change p2's third card to n2 → winner=10.
4. **HAND_MAX and simultaneous inputs.**
   - p1 receives 5 cards of n1 without standing → finished. p2 stand → JUDGE.
   - Same-cycle `card_valid`+`stand` for p2 with score 0 → the card is counted, then stood.
5. **Mid-game abort.**
   - `start` during PLAY with score1=9 → score1=0, count1=0 next cycle, still PLAY.
   - rst low mid-JUDGE → IDLE, all outputs 0 immediately.
   - `card_valid` in IDLE/DONE → no change.
